// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-back path.
package wb_pkg;
  localparam int REG_ADDR_W         = 5;
  localparam int XLEN               = 32;
  localparam int STARVE_LIMIT_DFLT  = 4;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
  } wb_req_t;
endpackage

// File: rtl/regs_scoreboard.sv
// Pending-write scoreboard: marks registers awaiting a multi-cycle result and
// raises a stall when ID touches one of them.
module regs_scoreboard
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_set_en,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  input  logic                  i_clr_en,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_rd_wen,
  output logic                  o_stall
);
  logic [31:1] r_pending;
  logic [31:0] w_set_mask, w_clr_mask, w_pend32;

  // Bit 0 of the masks is dropped, so x0 can never be marked.
  assign w_set_mask = i_set_en ? (32'd1 << i_set_addr) : 32'd0;
  assign w_clr_mask = i_clr_en ? (32'd1 << i_clr_addr) : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pending <= '0;
    else      r_pending <= (r_pending & ~w_clr_mask[31:1]) | w_set_mask[31:1];
  end

  // x0 reads as never pending through the zero in bit 0.
  assign w_pend32 = {r_pending, 1'b0};
  assign o_stall  = w_pend32[i_rs1] | w_pend32[i_rs2] | (i_rd_wen & w_pend32[i_rd]);
endmodule

// File: rtl/regs_wb_ctrl.sv
// Write-back controller: arbitrates the single register-file write port between
// EX and the multi-cycle unit, with starvation relief and an ID stall scoreboard.
module regs_wb_ctrl
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_waddr_i,
  input  logic [XLEN-1:0]       ex_wdata_i,
  output logic                  ex_ready_o,
  input  logic                  mc_issue_i,
  input  logic [REG_ADDR_W-1:0] mc_issue_rd_i,
  input  logic                  mc_valid_i,
  input  logic [REG_ADDR_W-1:0] mc_waddr_i,
  input  logic [XLEN-1:0]       mc_wdata_i,
  output logic                  mc_ready_o,
  input  logic [REG_ADDR_W-1:0] rs1_raddr_i,
  input  logic [REG_ADDR_W-1:0] rs2_raddr_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_rd_wen_i,
  output logic                  stall_o,
  output logic [REG_ADDR_W-1:0] rd_waddr_o,
  output logic [XLEN-1:0]       rd_wdata_o,
  output logic                  rd_wen_o
);
  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  wb_req_t       w_ex, w_mc;
  logic [CW-1:0] r_starve_cnt;
  logic          w_starved, w_mc_gnt, w_ex_gnt, w_sb_stall;

  assign w_ex = '{valid: ex_valid_i, waddr: ex_waddr_i, wdata: ex_wdata_i};
  assign w_mc = '{valid: mc_valid_i, waddr: mc_waddr_i, wdata: mc_wdata_i};

  assign w_starved  = (r_starve_cnt == LIMIT);
  // EX has priority until MC has been refused STARVE_LIMIT cycles in a row.
  assign w_mc_gnt   = rst & w_mc.valid & (!w_ex.valid | w_starved);
  assign ex_ready_o = rst & !(w_mc.valid & w_starved);
  assign mc_ready_o = w_mc_gnt;
  assign w_ex_gnt   = w_ex.valid & ex_ready_o;

  always_comb begin
    rd_wen_o   = 1'b0;
    rd_waddr_o = '0;
    rd_wdata_o = '0;
    if (w_mc_gnt) begin
      rd_wen_o   = 1'b1;
      rd_waddr_o = w_mc.waddr;
      rd_wdata_o = w_mc.wdata;
    end else if (w_ex_gnt) begin
      rd_wen_o   = 1'b1;
      rd_waddr_o = w_ex.waddr;
      rd_wdata_o = w_ex.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_starve_cnt <= '0;
    else if (!w_mc.valid || w_mc_gnt) r_starve_cnt <= '0;
    else if (!w_starved)            r_starve_cnt <= r_starve_cnt + 1'b1;
  end

  regs_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (mc_issue_i),
    .i_set_addr (mc_issue_rd_i),
    .i_clr_en   (w_mc_gnt),
    .i_clr_addr (w_mc.waddr),
    .i_rs1      (rs1_raddr_i),
    .i_rs2      (rs2_raddr_i),
    .i_rd       (id_rd_i),
    .i_rd_wen   (id_rd_wen_i),
    .o_stall    (w_sb_stall)
  );

  assign stall_o = rst & w_sb_stall;
endmodule

// File: tb/tb_regs_wb_ctrl.sv
// Directed bench for regs_wb_ctrl: table of single-cycle port-mux vectors plus
// hand sequences for starvation, scoreboard and reset behaviour.
module tb_regs_wb_ctrl;
  import wb_pkg::*;

  logic        clk = 1'b0, rst = 1'b0;
  logic        ex_valid_i, mc_issue_i, mc_valid_i, id_rd_wen_i;
  logic [4:0]  ex_waddr_i, mc_issue_rd_i, mc_waddr_i, rs1_raddr_i, rs2_raddr_i, id_rd_i;
  logic [31:0] ex_wdata_i, mc_wdata_i;
  logic        ex_ready_o, mc_ready_o, stall_o, rd_wen_o;
  logic [4:0]  rd_waddr_o;
  logic [31:0] rd_wdata_o;

  int errors = 0, checks = 0;

  regs_wb_ctrl #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_o),
    .mc_issue_i(mc_issue_i), .mc_issue_rd_i(mc_issue_rd_i),
    .mc_valid_i(mc_valid_i), .mc_waddr_i(mc_waddr_i), .mc_wdata_i(mc_wdata_i), .mc_ready_o(mc_ready_o),
    .rs1_raddr_i(rs1_raddr_i), .rs2_raddr_i(rs2_raddr_i), .id_rd_i(id_rd_i), .id_rd_wen_i(id_rd_wen_i),
    .stall_o(stall_o), .rd_waddr_o(rd_waddr_o), .rd_wdata_o(rd_wdata_o), .rd_wen_o(rd_wen_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exv; logic [4:0] exa; logic [31:0] exd;
    logic        mcv; logic [4:0] mca; logic [31:0] mcd;
    logic        wen; logic [4:0] wa;  logic [31:0] wd;
    logic        exr; logic       mcr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    ex_valid_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    mc_issue_i = 0; mc_issue_rd_i = 0;
    mc_valid_i = 0; mc_waddr_i = 0; mc_wdata_i = 0;
    rs1_raddr_i = 0; rs2_raddr_i = 0; id_rd_i = 0; id_rd_wen_i = 0;
  endtask

  task automatic port(input string tag, input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                      input logic exr, input logic mcr);
    chk({tag, ".wen"}, 32'(rd_wen_o), 32'(wen));
    chk({tag, ".waddr"}, 32'(rd_waddr_o), 32'(wa));
    chk({tag, ".wdata"}, rd_wdata_o, wd);
    chk({tag, ".ex_ready"}, 32'(ex_ready_o), 32'(exr));
    chk({tag, ".mc_ready"}, 32'(mc_ready_o), 32'(mcr));
  endtask

  initial begin
    vecs[0] = '{1, 5, 32'h1234, 0, 0, 0,             1, 5, 32'h1234, 1, 0};
    vecs[1] = '{0, 0, 0,        1, 7, 32'hB,          1, 7, 32'hB,    1, 1};
    vecs[2] = '{1, 3, 32'hA,    1, 7, 32'hB,          1, 3, 32'hA,    1, 0};
    vecs[3] = '{0, 0, 0,        0, 0, 0,              0, 0, 0,        1, 0};
    vecs[4] = '{1, 0, 32'h5,    0, 0, 0,              1, 0, 32'h5,    1, 0};
    vecs[5] = '{0, 9, 32'hDEAD, 0, 12, 32'hBEEF,      0, 0, 0,        1, 0};
    vecs[6] = '{0, 0, 0,        1, 31, 32'hFFFFFFFF,  1, 31, 32'hFFFFFFFF, 1, 1};

    // Reset held with every requester active
    idle();
    ex_valid_i = 1; ex_waddr_i = 2; ex_wdata_i = 32'h77;
    mc_valid_i = 1; mc_waddr_i = 6; mc_wdata_i = 32'h88;
    mc_issue_i = 1; mc_issue_rd_i = 9; rs1_raddr_i = 9;
    repeat (2) @(negedge clk);
    #1 port("reset", 0, 0, 0, 0, 0);
    chk("reset.stall", 32'(stall_o), 0);
    idle();
    @(negedge clk) rst = 1;
    for (int r = 1; r < 32; r += 5) begin
      rs1_raddr_i = 5'(r); rs2_raddr_i = 5'(r + 1);
      #1 chk("after_reset.stall", 32'(stall_o), 0);
    end
    idle();

    // Single-cycle mux vectors, each followed by an idle cycle to clear the starve counter
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ex_valid_i = vecs[i].exv; ex_waddr_i = vecs[i].exa; ex_wdata_i = vecs[i].exd;
      mc_valid_i = vecs[i].mcv; mc_waddr_i = vecs[i].mca; mc_wdata_i = vecs[i].mcd;
      #1 port($sformatf("vec%0d", i), vecs[i].wen, vecs[i].wa, vecs[i].wd, vecs[i].exr, vecs[i].mcr);
      @(negedge clk) idle();
    end

    // Collision then MC drains once EX goes idle
    @(negedge clk);
    ex_valid_i = 1; ex_waddr_i = 3; ex_wdata_i = 32'hA;
    mc_valid_i = 1; mc_waddr_i = 7; mc_wdata_i = 32'hB;
    #1 port("collide", 1, 3, 32'hA, 1, 0);
    @(negedge clk) ex_valid_i = 0;
    #1 port("collide_next", 1, 7, 32'hB, 1, 1);
    @(negedge clk) idle();
    @(negedge clk);

    // Starvation: EX valid every cycle, MC valid from cycle 0
    ex_valid_i = 1; ex_waddr_i = 1; ex_wdata_i = 32'h11;
    mc_valid_i = 1; mc_waddr_i = 2; mc_wdata_i = 32'h22;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c < 4) port($sformatf("starve_c%0d", c), 1, 1, 32'h11, 1, 0);
      else       port("starve_c4", 1, 2, 32'h22, 0, 1);
      @(negedge clk);
    end
    mc_valid_i = 0;
    #1 port("starve_c5", 1, 1, 32'h11, 1, 0);
    // Counter restarted: four more refusals before the next forced grant
    @(negedge clk) mc_valid_i = 1; mc_waddr_i = 8; mc_wdata_i = 32'h33;
    for (int c = 6; c < 11; c++) begin
      #1;
      if (c < 10) chk($sformatf("restarve_c%0d.mc_ready", c), 32'(mc_ready_o), 0);
      else        chk("restarve_c10.mc_ready", 32'(mc_ready_o), 1);
      @(negedge clk);
    end
    idle();
    @(negedge clk);

    // Scoreboard: issue x9, read it through rs2
    mc_issue_i = 1; mc_issue_rd_i = 9; rs2_raddr_i = 9;
    #1 chk("sb_issue_cycle.stall", 32'(stall_o), 0);
    @(negedge clk) mc_issue_i = 0;
    #1 chk("sb_pending.stall", 32'(stall_o), 1);
    @(negedge clk);
    #1 chk("sb_still.stall", 32'(stall_o), 1);
    mc_valid_i = 1; mc_waddr_i = 9; mc_wdata_i = 32'h99;
    #1 chk("sb_grant_cycle.stall", 32'(stall_o), 1);
    chk("sb_grant_cycle.mc_ready", 32'(mc_ready_o), 1);
    @(negedge clk) mc_valid_i = 0;
    #1 chk("sb_released.stall", 32'(stall_o), 0);

    // Issue to x0 never stalls
    mc_issue_i = 1; mc_issue_rd_i = 0;
    @(negedge clk) mc_issue_i = 0; rs1_raddr_i = 0; rs2_raddr_i = 0; id_rd_i = 0; id_rd_wen_i = 1;
    #1 chk("sb_x0.stall", 32'(stall_o), 0);
    id_rd_wen_i = 0;

    // Issue and grant on x9 in one cycle: set wins
    @(negedge clk) mc_issue_i = 1; mc_issue_rd_i = 9;
    mc_valid_i = 1; mc_waddr_i = 9; mc_wdata_i = 32'h5;
    @(negedge clk) idle(); rs1_raddr_i = 9;
    #1 chk("sb_set_wins.stall", 32'(stall_o), 1);
    // Grant x9 while issuing x10: both take effect
    mc_issue_i = 1; mc_issue_rd_i = 10; mc_valid_i = 1; mc_waddr_i = 9;
    @(negedge clk) idle(); rs1_raddr_i = 9;
    #1 chk("sb_clear_other.stall", 32'(stall_o), 0);
    rs1_raddr_i = 10;
    #1 chk("sb_set_other.stall", 32'(stall_o), 1);

    // WAW guard on x4, then reset drops it
    @(negedge clk) idle(); mc_issue_i = 1; mc_issue_rd_i = 4;
    @(negedge clk) mc_issue_i = 0; id_rd_i = 4; id_rd_wen_i = 1;
    #1 chk("waw.stall", 32'(stall_o), 1);
    id_rd_wen_i = 0;
    #1 chk("waw_nowen.stall", 32'(stall_o), 0);
    id_rd_wen_i = 1;
    #1 rst = 0;
    #1 chk("waw_reset.stall", 32'(stall_o), 0);
    @(negedge clk) rst = 1;
    #1 chk("waw_after_reset.stall", 32'(stall_o), 0);
    rs1_raddr_i = 10;
    #1 chk("x10_after_reset.stall", 32'(stall_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regs_wb_ctrl.md
# regs_wb_ctrl

Write-back controller for the 32×32 register file. It shares the single register-file write port between the single-cycle EX result path and a multi-cycle unit (divider/load) result path, and it keeps a pending-write scoreboard that stalls ID while a source or destination register awaits a multi-cycle result. It sits between EX/the multi-cycle unit and `regs`. The read bypass inside `regs` covers same-cycle write/read, so this block does no forwarding.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive refused cycles after which the multi-cycle result wins the port (≥1).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `ex_valid_i`  in  1  EX has a write-back this cycle.
- `ex_waddr_i`  in  5  EX destination register.
- `ex_wdata_i`  in  32  EX result.
- `ex_ready_o`  out  1  EX write accepted; low means EX holds its write.
- `mc_issue_i`  in  1  a multi-cycle op is issued this cycle.
- `mc_issue_rd_i`  in  5  destination of the issued op.
- `mc_valid_i`  in  1  multi-cycle result available.
- `mc_waddr_i`  in  5  multi-cycle destination.
- `mc_wdata_i`  in  32  multi-cycle result.
- `mc_ready_o`  out  1  multi-cycle result accepted.
- `rs1_raddr_i`  in  5  ID source 1 (same value driven to `regs`).
- `rs2_raddr_i`  in  5  ID source 2.
- `id_rd_i`  in  5  ID destination.
- `id_rd_wen_i`  in  1  ID instruction writes `id_rd_i`.
- `stall_o`  out  1  ID must hold.
- `rd_waddr_o`  out  5  to `regs.rd_waddr_i`.
- `rd_wdata_o`  out  32  to `regs.rd_wdata_i`.
- `rd_wen_o`  out  1  to `regs.rd_wen`.

## Operation
- State consists of `pending[31:1]`, the scoreboard, and `starve_cnt`, which is `$clog2(STARVE_LIMIT+1)` bits wide.
- `starved = (starve_cnt == STARVE_LIMIT)`.
- `mc_ready_o = mc_valid_i & (!ex_valid_i | starved)`.
- `ex_ready_o = !(mc_valid_i & starved)`.
- EX grant = `ex_valid_i & ex_ready_o`.
- Port mux: the MC grant selects the `mc_*` fields. Otherwise the EX grant selects the `ex_*` fields. With no grant, `rd_wen_o`=0 and the address and data outputs are 0.
- `rd_wen_o` = (EX grant) | (MC grant). A grant to address 0 is legal; `regs` discards it.
- Starve counter:
  - Increments when `mc_valid_i & !mc_ready_o`, saturating at `STARVE_LIMIT`.
  - Clears to 0 on an MC grant or when `mc_valid_i`=0.
- Scoreboard:
  - `mc_issue_i` with rd≠0 sets `pending[rd]`.
  - An MC grant with `mc_waddr_i`≠0 clears `pending[mc_waddr_i]`.
  - If a set and a clear hit the same rd in one cycle, the set wins.
  - A set and a clear on different registers both take effect.
- `stall_o` = (`rs1_raddr_i`≠0 & `pending[rs1]`) | (`rs2_raddr_i`≠0 & `pending[rs2]`) | (`id_rd_wen_i` & `id_rd_i`≠0 & `pending[id_rd]`). The last term is the WAW guard.
- `stall_o` evaluates registered `pending` only. A same-cycle MC grant still stalls that cycle. The write itself lands through the `regs` bypass, and the stall releases next cycle.
- While `rst`=0:
  - `pending`=0 and `starve_cnt`=0 (asynchronous clear).
  - `rd_wen_o`, `ex_ready_o`, `mc_ready_o` and `stall_o` are forced 0.
  - `rd_waddr_o` and `rd_wdata_o` are 0.
  - Reset asserted mid-operation drops any in-flight pending marks. The multi-cycle unit is reset by the same `rst`.

## Timing
- The write port path is purely combinational: inputs to `rd_*_o` and `*_ready_o` in the same cycle, with zero latency.
- `pending` and `starve_cnt` update on the rising edge of `clk`.
- A register issued at edge N stalls dependent ID reads from cycle N+1 onward.
- Starvation example with `STARVE_LIMIT`=4 and EX valid every cycle:
  - MC is refused in cycles 0–3.
  - MC is granted in cycle 4, while `ex_ready_o`=0.
  - EX is granted in cycle 5.
- Handshake rules:
  - Requesters hold valid, address and data stable until ready.
  - Ready never depends on a requester's own data.

## Structure
- Shared package `wb_pkg` holds:
  - `REG_ADDR_W`=5, `XLEN`=32 and the default `STARVE_LIMIT`.
  - The `wb_req_t` struct {valid, waddr, wdata}, reused by EX and the multi-cycle unit.
- Sub-module `regs_scoreboard` contains the pending vector plus the set/clear/stall logic. Arbitration and the starve counter stay in the top level.

## Test plan
- Reset: hold `rst`=0 with all valids=1 → `rd_wen_o`=0, both readies=0, `stall_o`=0. After release, `pending`=0.
- EX only: EX writes x5=0x1234 → same cycle `rd_wen_o`=1, `rd_waddr_o`=5, `rd_wdata_o`=0x1234, `ex_ready_o`=1.
- Collision: EX (x3=0xA) and MC (x7=0xB) valid in the same cycle with the counter at 0 → EX is granted and `mc_ready_o`=0. Next cycle, with EX idle → x7=0xB is written.
- Starvation: EX valid continuously, MC valid from cycle 0, `STARVE_LIMIT`=4 → MC is granted exactly in cycle 4 with `ex_ready_o`=0. EX resumes in cycle 5 and the counter returns to 0.
- Scoreboard: issue to x9, then ID `rs2_raddr_i`=9 → `stall_o`=1 until the cycle after the MC grant to x9. Also:
  - Issuing x0 never stalls.
  - Issuing x9 in the same cycle as an MC grant to x9 keeps x9 pending.
- WAW and reset: with x4 pending, set `id_rd_i`=4 and `id_rd_wen_i`=1 → `stall_o`=1. Assert `rst` → stall drops immediately and x4 is cleared.
